// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and timing constants for the button conditioner
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // 50 MHz board timing
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;

    // Shortened timing for simulation
    localparam int SIM_DEBOUNCE_CYCLES = 4;
    localparam int SIM_REPEAT_DELAY    = 10;
    localparam int SIM_REPEAT_PERIOD   = 5;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, debounce counter and stable level
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_toggle
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differs;

    assign w_differs = (r_sync[1] != r_stable);
    // The toggle is visible combinationally so the press pulse can be
    // registered downstream on the same edge the level changes.
    assign o_toggle  = w_differs && (r_cnt == CNT_W'(DEBOUNCE_CYCLES));
    assign o_level   = r_stable;

    // Synchronise the raw input and flip the stable level once it has disagreed long enough
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync   <= 2'b00;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (o_toggle) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced, auto-repeating, arbitrated button pulses
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int REPEAT_EN       = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_plus_raw,
    input  logic btn_minus_raw,
    input  logic btn_clear_raw,
    output logic plus_pulse,
    output logic minus_pulse,
    output logic clear_pulse,
    output logic plus_level,
    output logic minus_level,
    output logic clear_level
);

    localparam int   RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int   RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic RPT_ON  = (REPEAT_EN != 0);

    logic w_plus_tgl, w_minus_tgl, w_clear_tgl;
    logic w_plus_rise, w_plus_fall, w_minus_rise, w_minus_fall, w_clear_rise;
    logic w_plus_fire, w_minus_fire;

    rpt_state_t       r_plus_state, r_minus_state;
    logic [RPT_W-1:0] r_plus_cnt, r_minus_cnt;
    logic             r_plus_pulse, r_minus_pulse, r_clear_pulse;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_plus (
        .clk(clk), .reset_n(reset_n), .i_raw(btn_plus_raw),
        .o_level(plus_level), .o_toggle(w_plus_tgl)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_minus (
        .clk(clk), .reset_n(reset_n), .i_raw(btn_minus_raw),
        .o_level(minus_level), .o_toggle(w_minus_tgl)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk(clk), .reset_n(reset_n), .i_raw(btn_clear_raw),
        .o_level(clear_level), .o_toggle(w_clear_tgl)
    );

    assign w_plus_rise  = w_plus_tgl  & ~plus_level;
    assign w_plus_fall  = w_plus_tgl  &  plus_level;
    assign w_minus_rise = w_minus_tgl & ~minus_level;
    assign w_minus_fall = w_minus_tgl &  minus_level;
    assign w_clear_rise = w_clear_tgl & ~clear_level;

    // Press or timer expiry requests a pulse; a release on the same edge cancels it
    always_comb begin
        w_plus_fire  = w_plus_rise |
                       (RPT_ON && !w_plus_fall && (r_plus_state != IDLE) && (r_plus_cnt == '0));
        w_minus_fire = w_minus_rise |
                       (RPT_ON && !w_minus_fall && (r_minus_state != IDLE) && (r_minus_cnt == '0));
    end

    // Plus auto-repeat FSM: initial delay, then fixed period, until release
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_plus_state <= IDLE;
            r_plus_cnt   <= '0;
        end else if (w_plus_fall) begin
            r_plus_state <= IDLE;
            r_plus_cnt   <= '0;
        end else begin
            case (r_plus_state)
                IDLE: if (w_plus_rise && RPT_ON) begin
                    r_plus_state <= DELAY;
                    r_plus_cnt   <= RPT_W'(REPEAT_DELAY - 1);
                end
                DELAY, REPEAT: if (r_plus_cnt == '0) begin
                    r_plus_state <= REPEAT;
                    r_plus_cnt   <= RPT_W'(REPEAT_PERIOD - 1);
                end else begin
                    r_plus_cnt <= r_plus_cnt - 1'b1;
                end
                default: r_plus_state <= IDLE;
            endcase
        end
    end

    // Minus auto-repeat FSM: identical timing to plus
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_minus_state <= IDLE;
            r_minus_cnt   <= '0;
        end else if (w_minus_fall) begin
            r_minus_state <= IDLE;
            r_minus_cnt   <= '0;
        end else begin
            case (r_minus_state)
                IDLE: if (w_minus_rise && RPT_ON) begin
                    r_minus_state <= DELAY;
                    r_minus_cnt   <= RPT_W'(REPEAT_DELAY - 1);
                end
                DELAY, REPEAT: if (r_minus_cnt == '0) begin
                    r_minus_state <= REPEAT;
                    r_minus_cnt   <= RPT_W'(REPEAT_PERIOD - 1);
                end else begin
                    r_minus_cnt <= r_minus_cnt - 1'b1;
                end
                default: r_minus_state <= IDLE;
            endcase
        end
    end

    // One pulse per cycle: clear beats plus beats minus; losers are dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clear_pulse <= 1'b0;
            r_plus_pulse  <= 1'b0;
            r_minus_pulse <= 1'b0;
        end else begin
            r_clear_pulse <= w_clear_rise;
            r_plus_pulse  <= w_plus_fire & ~w_clear_rise;
            r_minus_pulse <= w_minus_fire & ~w_clear_rise & ~w_plus_fire;
        end
    end

    assign plus_pulse  = r_plus_pulse;
    assign minus_pulse = r_minus_pulse;
    assign clear_pulse = r_clear_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
module tb_button_conditioner;
    import btn_pkg::*;

    typedef struct {
        int       cyc;
        logic [2:0] p;
        logic [2:0] l;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic btn_plus_raw = 1'b0, btn_minus_raw = 1'b0, btn_clear_raw = 1'b0;
    logic plus_pulse, minus_pulse, clear_pulse;
    logic plus_level, minus_level, clear_level;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    logic [2:0] prev_l = 3'b000;

    button_conditioner #(
        .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES),
        .REPEAT_DELAY(SIM_REPEAT_DELAY),
        .REPEAT_PERIOD(SIM_REPEAT_PERIOD),
        .REPEAT_EN(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .btn_plus_raw(btn_plus_raw), .btn_minus_raw(btn_minus_raw), .btn_clear_raw(btn_clear_raw),
        .plus_pulse(plus_pulse), .minus_pulse(minus_pulse), .clear_pulse(clear_pulse),
        .plus_level(plus_level), .minus_level(minus_level), .clear_level(clear_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: any pulse or level change must match the head of the expected queue
    always @(negedge clk) begin
        logic [2:0] op, ol;
        ev_t e;
        op = {clear_pulse, minus_pulse, plus_pulse};
        ol = {clear_level, minus_level, plus_level};
        if (reset_n) begin
            if (op != 3'b000 || ol != prev_l) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event cyc=%0d actual p=%b l=%b required none", cyc, op, ol);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.p != op || e.l != ol) begin
                        errors++;
                        $display("FAIL event actual cyc=%0d p=%b l=%b required cyc=%0d p=%b l=%b",
                                 cyc, op, ol, e.cyc, e.p, e.l);
                    end
                end
            end
            prev_l = ol;
        end else begin
            prev_l = 3'b000;
        end
    end

    task automatic expect_ev(input int base, input int e, input logic [2:0] p, input logic [2:0] l);
        ev_t ev;
        ev.cyc = base + e;
        ev.p   = p;
        ev.l   = l;
        exp_q.push_back(ev);
    endtask

    task automatic check_outputs_zero(input string name);
        logic [5:0] v;
        v = {clear_pulse, minus_pulse, plus_pulse, clear_level, minus_level, plus_level};
        checks++;
        if (v != 6'b0) begin
            errors++;
            $display("FAIL %s actual=%b required=000000", name, v);
        end
    endtask

    // Raw button pattern {clear, minus, plus} for test t at relative edge e
    function automatic logic [2:0] raw_at(input int t, input int e);
        case (t)
            1: return {2'b00, e < 8};
            2: return {1'b0, (e >= 10) ? (e < 20) : (((e / 2) % 2) == 1), 1'b0};
            3: return {2'b00, e < 30};
            4: return {e < 30, 2'b00};
            5: return {e < 10, 1'b0, e < 20};
            6: return {2'b00, e < 34};
            default: return 3'b000;
        endcase
    endfunction

    task automatic run_test(input int t);
        int base;
        logic [2:0] r;
        @(negedge clk);
        base = cyc + 1;
        case (t)
            1: begin
                expect_ev(base, 6, 3'b001, 3'b001);
                expect_ev(base, 14, 3'b000, 3'b000);
            end
            2: begin
                expect_ev(base, 16, 3'b010, 3'b010);
                expect_ev(base, 26, 3'b000, 3'b000);
            end
            3: begin
                expect_ev(base, 6, 3'b001, 3'b001);
                expect_ev(base, 16, 3'b001, 3'b001);
                expect_ev(base, 21, 3'b001, 3'b001);
                expect_ev(base, 26, 3'b001, 3'b001);
                expect_ev(base, 31, 3'b001, 3'b001);
                expect_ev(base, 36, 3'b000, 3'b000);
            end
            4: begin
                expect_ev(base, 6, 3'b100, 3'b100);
                expect_ev(base, 36, 3'b000, 3'b000);
            end
            5: begin
                expect_ev(base, 6, 3'b100, 3'b101);
                expect_ev(base, 16, 3'b001, 3'b001);
                expect_ev(base, 21, 3'b001, 3'b001);
                expect_ev(base, 26, 3'b000, 3'b000);
            end
            6: begin
                expect_ev(base, 6, 3'b001, 3'b001);
                expect_ev(base, 16, 3'b001, 3'b001);
                expect_ev(base, 31, 3'b001, 3'b001);
                expect_ev(base, 40, 3'b000, 3'b000);
            end
            default: ;
        endcase
        for (int e = 0; e < 55; e++) begin
            if (t == 6 && e == 20) begin
                #2 reset_n = 1'b0;
                #1 check_outputs_zero("async_reset_outputs");
            end
            if (t == 6 && e == 25) reset_n = 1'b1;
            r = raw_at(t, e);
            btn_clear_raw = r[2];
            btn_minus_raw = r[1];
            btn_plus_raw  = r[0];
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events test=%0d actual_left=%0d required=0", t, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_state");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int t = 1; t <= 6; t++) run_test(t);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
